spi_secondary: RTL and testbench

SPI_SECONDARY -- requirements
Module: spi_secondary

---
 rtl/spi_secondary_if.sv | 38 +++
 rtl/spi_secondary.sv | 157 +++++++++++++++
 tb/tb_spi_secondary.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/spi_secondary_if.sv
// rtl/spi_secondary_if.sv - SPI secondary pins plus host-side word bus; status signals exist only with SPI_SECONDARY_STATUS_EN
interface spi_secondary_if #(
    parameter int DWIDTH = 8
);
    logic              sclk;
    logic              cs;
    logic              mosi;
    logic              miso;
    logic [DWIDTH-1:0] din;
    logic              wr;
    logic [DWIDTH-1:0] dout;
    logic              rd;
    logic              rx_valid;
    logic              busy;
`ifdef SPI_SECONDARY_STATUS_EN
    logic              overrun;
    logic              underrun;
    logic              status_clr;

    modport master (
        output sclk, cs, mosi, din, wr, rd, status_clr,
        input  miso, dout, rx_valid, busy, overrun, underrun
    );
    modport slave (
        input  sclk, cs, mosi, din, wr, rd, status_clr,
        output miso, dout, rx_valid, busy, overrun, underrun
    );
`else
    modport master (
        output sclk, cs, mosi, din, wr, rd,
        input  miso, dout, rx_valid, busy
    );
    modport slave (
        input  sclk, cs, mosi, din, wr, rd,
        output miso, dout, rx_valid, busy
    );
`endif
endinterface

// File: rtl/spi_secondary.sv
// rtl/spi_secondary.sv - SPI secondary with oversampled pins; optional sticky status via SPI_SECONDARY_STATUS_EN
module spi_secondary #(
    parameter int DWIDTH           = 8,
    parameter bit CPHA_SAMPLE_RISE = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_secondary_if.slave bus
);
    localparam int CW = $clog2(DWIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [2:0]        sclk_s;
    logic [2:0]        cs_s;
    logic [1:0]        mosi_s;
    logic [1:0]        fill_cnt;
    logic              cs_armed;

    state_t            state;
    logic [CW-1:0]     bit_cnt;
    logic [DWIDTH-1:0] tx_buf;
    logic [DWIDTH-1:0] tx_sr;
    logic [DWIDTH-1:0] rx_sr;
    logic [DWIDTH-1:0] rx_next;
    logic [DWIDTH-1:0] dout_q;
    logic              miso_q;
    logic              rx_valid_q;
    logic              busy_q;

    logic sclk_rise, sclk_fall, sample_edge, drive_edge;
    logic cs_fall, cs_rise, frame_start, frame_done;

    // A cs low seen straight out of reset must not look like a falling edge,
    // so starts are only accepted once the pipeline has held a genuine high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s   <= 3'b000;
            cs_s     <= 3'b111;
            mosi_s   <= 2'b00;
            fill_cnt <= 2'd0;
            cs_armed <= 1'b0;
        end else begin
            sclk_s <= {sclk_s[1:0], bus.sclk};
            cs_s   <= {cs_s[1:0], bus.cs};
            mosi_s <= {mosi_s[0], bus.mosi};
            if (fill_cnt != 2'd3)
                fill_cnt <= fill_cnt + 2'd1;
            if (fill_cnt == 2'd3 && cs_s[2])
                cs_armed <= 1'b1;
        end
    end

    assign sclk_rise   = sclk_s[1] & ~sclk_s[2];
    assign sclk_fall   = ~sclk_s[1] & sclk_s[2];
    assign sample_edge = CPHA_SAMPLE_RISE ? sclk_rise : sclk_fall;
    assign drive_edge  = CPHA_SAMPLE_RISE ? sclk_fall : sclk_rise;
    assign cs_fall     = ~cs_s[1] & cs_s[2] & cs_armed;
    assign cs_rise     = cs_s[1] & ~cs_s[2];

    assign frame_start = (state == IDLE) && cs_fall;
    assign frame_done  = (state == SHIFT) && !cs_rise && sample_edge &&
                         (bit_cnt == CW'(DWIDTH - 1));
    assign rx_next     = (rx_sr << 1) | {{(DWIDTH-1){1'b0}}, mosi_s[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            tx_buf     <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            dout_q     <= '0;
            miso_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (bus.wr)
                tx_buf <= bus.din;
            if (bus.rd)
                rx_valid_q <= 1'b0;

            case (state)
                IDLE: begin
                    miso_q <= tx_buf[DWIDTH-1];
                    if (frame_start) begin
                        state   <= SHIFT;
                        busy_q  <= 1'b1;
                        tx_sr   <= tx_buf;
                        rx_sr   <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        bit_cnt <= '0;
                        miso_q  <= tx_buf[DWIDTH-1];
                    end else if (sample_edge) begin
                        rx_sr <= rx_next;
                        if (frame_done) begin
                            dout_q     <= rx_next;
                            rx_valid_q <= 1'b1;
                            state      <= IDLE;
                            busy_q     <= 1'b0;
                            bit_cnt    <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (drive_edge && bit_cnt != '0) begin
                        // bit_cnt == 0 means no sample yet: a leading drive edge is ignored
                        tx_sr  <= tx_sr << 1;
                        miso_q <= tx_sr[DWIDTH-2];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.miso     = miso_q;
    assign bus.dout     = dout_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy     = busy_q;

`ifdef SPI_SECONDARY_STATUS_EN
    logic wr_since_start;
    logic overrun_q;
    logic underrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_since_start <= 1'b0;
            overrun_q      <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            if (frame_start)
                wr_since_start <= bus.wr;
            else if (bus.wr)
                wr_since_start <= 1'b1;

            if (bus.status_clr) begin
                overrun_q  <= 1'b0;
                underrun_q <= 1'b0;
            end
            if (frame_done && rx_valid_q)
                overrun_q <= 1'b1;
            if (frame_start && !wr_since_start)
                underrun_q <= 1'b1;
        end
    end

    assign bus.overrun  = overrun_q;
    assign bus.underrun = underrun_q;
`endif
endmodule

// File: tb/tb_spi_secondary.sv
// tb/tb_spi_secondary.sv - randomized and directed bench for spi_secondary against a word-level model
module tb_spi_secondary;
    logic clk;
    logic rst_n;

    spi_secondary_if #(.DWIDTH(8)) bus ();

    spi_secondary #(.DWIDTH(8), .CPHA_SAMPLE_RISE(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_tx_buf;
    logic [7:0] m_dout;
    logic       m_rx_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [7:0] d);
        bus.din = d;
        bus.wr  = 1'b1;
        tick(1);
        bus.wr  = 1'b0;
        m_tx_buf = d;
    endtask

    task automatic host_rd();
        bus.rd = 1'b1;
        tick(1);
        bus.rd = 1'b0;
        m_rx_valid = 1'b0;
        check("rd_clear", bus.rx_valid, 0);
    endtask

    // One primary-side frame: nbits full sclk periods, optional host write in
    // the low phase of bit wr_at, optional rd landing on the completion cycle.
    task automatic frame(input logic [7:0] mo, input int nbits, input int wr_at,
                         input logic [7:0] wr_d, input bit rd_at_end);
        logic [7:0] exp_tx;
        logic [7:0] got;
        exp_tx = m_tx_buf;
        got    = '0;
        bus.cs   = 1'b0;
        bus.mosi = mo[7];
        tick(6);
        check("busy_start", bus.busy, 1);
        for (int i = 0; i < nbits; i++) begin
            got = {got[6:0], bus.miso};
            bus.sclk = 1'b1;
            if (i == 7) begin
                tick(2);
                if (rd_at_end) bus.rd = 1'b1;
                tick(1);
                bus.rd = 1'b0;
                check("rx_valid_lat", bus.rx_valid, 1);
                check("dout_lat", bus.dout, mo);
                tick(2);
            end else begin
                tick(5);
            end
            bus.sclk = 1'b0;
            if (i == wr_at) host_wr(wr_d);
            else tick(1);
            tick(1);
            if (i < 7) bus.mosi = mo[6-i];
            tick(3);
        end
        if (nbits == 8) begin
            m_dout     = mo;
            m_rx_valid = 1'b1;
        end
        tick(3);
        bus.cs = 1'b1;
        tick(4);
        check("busy_end", bus.busy, 0);
        check("miso_bits", got, exp_tx >> (8 - nbits));
        check("dout", bus.dout, m_dout);
        check("rx_valid", bus.rx_valid, m_rx_valid);
        check("miso_idle", bus.miso, m_tx_buf[7]);
        tick(2);
    endtask

    initial begin
        int         nb;
        int         wa;
        bit         re;
        logic [7:0] rv;

        rst_n    = 1'b0;
        bus.sclk = 1'b0;
        bus.cs   = 1'b1;
        bus.mosi = 1'b0;
        bus.din  = '0;
        bus.wr   = 1'b0;
        bus.rd   = 1'b0;
`ifdef SPI_SECONDARY_STATUS_EN
        bus.status_clr = 1'b0;
`endif
        m_tx_buf   = '0;
        m_dout     = '0;
        m_rx_valid = 1'b0;
        tick(3);
        check("rst_miso", bus.miso, 0);
        check("rst_dout", bus.dout, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        tick(10);

        host_wr(8'hA5);
        frame(8'h3C, 8, -1, 8'h00, 1'b0);

        frame(8'h11, 8, -1, 8'h00, 1'b0);
        frame(8'h22, 8, -1, 8'h00, 1'b0);
`ifdef SPI_SECONDARY_STATUS_EN
        check("overrun", bus.overrun, 1);
`endif

        frame(8'hFF, 5, -1, 8'h00, 1'b0);

        host_wr(8'hF0);
        frame(8'hAA, 8, 3, 8'h0F, 1'b0);
        frame(8'h55, 8, -1, 8'h00, 1'b0);

        host_rd();
        frame(8'h77, 8, -1, 8'h00, 1'b1);

        bus.cs   = 1'b0;
        bus.mosi = 1'b1;
        tick(6);
        repeat (3) begin
            bus.sclk = 1'b1;
            tick(5);
            bus.sclk = 1'b0;
            tick(5);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_miso", bus.miso, 0);
        check("midrst_dout", bus.dout, 0);
        check("midrst_rx_valid", bus.rx_valid, 0);
        check("midrst_busy", bus.busy, 0);
        m_tx_buf   = '0;
        m_dout     = '0;
        m_rx_valid = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        check("no_false_start", bus.busy, 0);
        bus.cs = 1'b1;
        tick(10);
        frame(8'h81, 8, -1, 8'h00, 1'b0);

        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                rv = 8'($urandom);
                host_wr(rv);
            end
            if (m_rx_valid && $urandom_range(0, 2) == 0) host_rd();
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 8;
            wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
            re = (nb == 8) && ($urandom_range(0, 3) == 0);
            rv = 8'($urandom);
            frame(rv, nb, wa, 8'($urandom), re);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
